joy_serializer: RTL

- Device-side counterpart of the joystick decoder: emulates the two cascaded 8-bit parallel-in/serial-out shift registers on the joystick interface.
- Latches two joysticks' button states when the host asserts joy_load_n, then shifts them out on joy_data, one bit per rising edge of host-driven joy_clk.
- Used on the joystick adapter build and as the bench model for the decoder.
- joy_clk and joy_load_n are asynchronous to clk; the block synchronises and deglitches them.

---
 rtl/joy_serializer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/joy_serializer.sv
// Joystick-side emulation of two cascaded 8-bit PISO shift registers.
// Host joy_clk/joy_load_n are synchronised and deglitched before use.
module joy_serializer #(
    parameter int unsigned FILTER = 2,
    parameter logic        FILL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       joy_clk,
    input  logic       joy_load_n,
    output logic       joy_data,
    input  logic [7:0] joy1_n,
    input  logic [7:0] joy2_n,
    output logic       frame_done,
    output logic       overrun,
    output logic [4:0] shift_count
);

    typedef enum logic {
        ST_SHIFT = 1'b0,
        ST_LOAD  = 1'b1
    } state_t;

    localparam logic [3:0] FILT      = 4'(FILTER);
    localparam logic [4:0] FRAME_LEN = 5'd16;

    // Channel 0 is joy_clk, channel 1 is joy_load_n.
    logic [1:0] raw_in;
    logic [1:0] filt_q;
    logic [1:0] filt_d;

    assign raw_in = {joy_load_n, joy_clk};

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        localparam logic RST_VAL = (gi == 1);

        logic [1:0] sync_q;
        logic [3:0] cnt_q;
        logic [3:0] cnt_d;
        logic       val_q;
        logic       val_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= {2{RST_VAL}};
                cnt_q  <= 4'd0;
                val_q  <= RST_VAL;
            end else begin
                sync_q <= {sync_q[0], raw_in[gi]};
                cnt_q  <= cnt_d;
                val_q  <= val_d;
            end
        end

        // A level change is accepted only after FILTER consecutive differing samples.
        always_comb begin
            cnt_d = 4'd0;
            val_d = val_q;
            if (sync_q[1] != val_q) begin
                if (cnt_q + 4'd1 == FILT) begin
                    val_d = sync_q[1];
                    cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end

        assign filt_q[gi] = val_q;
        assign filt_d[gi] = val_d;
    end

    state_t      state_q;
    state_t      state_d;
    logic [15:0] sr_q;
    logic [15:0] sr_d;
    logic [4:0]  count_q;
    logic [4:0]  count_d;
    logic        overrun_q;
    logic        overrun_d;
    logic        frame_done_q;
    logic        frame_done_d;
    logic        clk_prev_q;
    logic        clk_rise;

    assign clk_rise = filt_q[0] & ~clk_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SHIFT;
            sr_q         <= 16'hFFFF;
            count_q      <= 5'd0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            clk_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
            clk_prev_q   <= filt_q[0];
        end
    end

    // State follows the filtered load strobe so LOAD takes effect on the acceptance edge.
    always_comb begin
        state_d      = filt_d[1] ? ST_SHIFT : ST_LOAD;
        sr_d         = sr_q;
        count_d      = count_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_LOAD: begin
                sr_d      = {joy1_n, joy2_n};
                count_d   = 5'd0;
                overrun_d = 1'b0;
            end
            default: begin
                if (clk_rise) begin
                    sr_d = {sr_q[14:0], FILL};
                    if (count_q < FRAME_LEN) begin
                        count_d = count_q + 5'd1;
                    end
                    if (count_q == FRAME_LEN - 5'd1) begin
                        frame_done_d = 1'b1;
                    end
                    if (count_q == FRAME_LEN) begin
                        overrun_d = 1'b1;
                    end
                end
            end
        endcase
    end

    assign joy_data    = sr_q[15];
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign shift_count = count_q;

endmodule
